alu_issue_ctrl: RTL and testbench

- Sequencer that drives the registered ALU.
- Fetches 32-bit instruction words over a request/valid handshake and decodes them into alu_sel/alu_control.
- Reads operands from an internal 8x32 register file and presents them to the ALU.
- Captures alu_result/bt one cycle later, then writes the result back or updates the PC on a taken branch.

---
 rtl/alu_issue_ctrl_if.sv | 27 ++
 rtl/alu_issue_ctrl.sv | 129 ++++++++++++
 tb/tb_alu_issue_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_if.sv
// Fetch and ALU-side signals of the issue controller, grouped so the
// controller (master) and the fetch/ALU environment (slave) see one bundle.
`timescale 1ns/1ps
interface alu_issue_ctrl_if #(
  parameter int PC_W = 8
) ();
  logic            fetch_req;
  logic [PC_W-1:0] fetch_addr;
  logic            instr_valid;
  logic [31:0]     instr;
  logic [31:0]     alu_read_data1;
  logic [31:0]     alu_read_data2;
  logic [2:0]      alu_control;
  logic [1:0]      alu_sel;
  logic [31:0]     alu_result;
  logic            alu_bt;

  modport master (
    output fetch_req, fetch_addr, alu_read_data1, alu_read_data2, alu_control, alu_sel,
    input  instr_valid, instr, alu_result, alu_bt
  );

  modport slave (
    input  fetch_req, fetch_addr, alu_read_data1, alu_read_data2, alu_control, alu_sel,
    output instr_valid, instr, alu_result, alu_bt
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle sequencer for a registered ALU: FETCH -> DECODE -> EXEC -> WB,
// with an 8x32 register file, branch PC update and a retired-instruction count.
`timescale 1ns/1ps
module alu_issue_ctrl #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  alu_issue_ctrl_if.master     bus,
  output logic                 retire,
  output logic                 illegal,
  output logic [CNT_W-1:0]     retired_cnt,
  input  logic [2:0]           dbg_addr,
  output logic [31:0]          dbg_data
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB} state_t;

  typedef struct packed {
    logic [1:0] sel;
    logic [2:0] ctrl;
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic [7:0] off;
  } instr_t;

  state_t                 r_state;
  instr_t                 r_instr;
  logic [PC_W-1:0]        r_pc;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_fetch_req;
  logic                   r_retire;
  logic                   r_illegal;
  logic [1:0]             r_alu_sel;
  logic [2:0]             r_alu_control;
  logic [31:0]            r_rd1;
  logic [31:0]            r_rd2;
  logic [31:0]            r_regs [8];

  logic signed [PC_W-1:0] w_br_off;
  logic                   w_unused_lo;

  assign w_br_off    = $signed(r_instr.off);
  assign w_unused_lo = ^bus.instr[9:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_instr       <= '0;
      r_pc          <= '0;
      r_cnt         <= '0;
      r_fetch_req   <= 1'b0;
      r_retire      <= 1'b0;
      r_illegal     <= 1'b0;
      r_alu_sel     <= 2'b00;
      r_alu_control <= 3'b000;
      r_rd1         <= '0;
      r_rd2         <= '0;
      // NOTE: the register file must read as zero after reset, so it is held in
      // flops with the async reset rather than mapped to a RAM macro.
      for (int i = 0; i < 8; i++) r_regs[i] <= '0;
    end else begin
      r_retire <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (run) begin
            r_state     <= S_FETCH;
            r_fetch_req <= 1'b1;
          end
        end
        S_FETCH: begin
          if (bus.instr_valid) begin
            r_instr     <= bus.instr[31:10];
            r_fetch_req <= 1'b0;
            r_state     <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_alu_sel     <= (r_instr.sel == 2'b11) ? 2'b00 : r_instr.sel;
          r_alu_control <= r_instr.ctrl;
          r_rd1         <= r_regs[r_instr.rs1];
          r_rd2         <= r_regs[r_instr.rs2];
          r_state       <= S_EXEC;
        end
        S_EXEC: begin
          // ALU samples the held operands at this edge; retire marks the WB cycle.
          r_retire <= 1'b1;
          r_state  <= S_WB;
        end
        S_WB: begin
          r_cnt <= r_cnt + 1'b1;
          case (r_instr.sel)
            2'b00, 2'b01: begin
              if (r_instr.rd != 3'd0) r_regs[r_instr.rd] <= bus.alu_result;
              r_pc <= r_pc + 1'b1;
            end
            2'b10: r_pc <= bus.alu_bt ? r_pc + w_br_off : r_pc + 1'b1;
            default: begin
              r_illegal <= 1'b1;
              r_pc      <= r_pc + 1'b1;
            end
          endcase
          if (run) begin
            r_state     <= S_FETCH;
            r_fetch_req <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.fetch_req      = r_fetch_req;
  assign bus.fetch_addr     = r_pc;
  assign bus.alu_read_data1 = r_rd1;
  assign bus.alu_read_data2 = r_rd2;
  assign bus.alu_control    = r_alu_control;
  assign bus.alu_sel        = r_alu_sel;
  assign retire             = r_retire;
  assign illegal            = r_illegal;
  assign retired_cnt        = r_cnt;
  assign dbg_data           = (dbg_addr == 3'd0) ? 32'd0 : r_regs[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: an architectural model predicts each
// retirement, a behavioural registered ALU answers the DUT, a monitor compares.
`timescale 1ns/1ps
module tb_alu_issue_ctrl;
  localparam int PC_W  = 8;
  localparam int CNT_W = 16;

  localparam logic [1:0] RR = 2'b00, ID = 2'b01, BR = 2'b10, BAD = 2'b11;
  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3, XOR_ = 3'd4;
  localparam logic [2:0] INC = 3'd0, BEQ = 3'd0, BNE = 3'd1, BLT = 3'd2;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             run = 1'b0;
  logic [2:0]       dbg_addr = 3'd0;
  logic [31:0]      dbg_data;
  logic             retire;
  logic             illegal;
  logic [CNT_W-1:0] retired_cnt;

  alu_issue_ctrl_if #(.PC_W(PC_W)) bus ();

  alu_issue_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .run(run), .bus(bus),
    .retire(retire), .illegal(illegal), .retired_cnt(retired_cnt),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_ret = 0;
  int prev_ret = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural ALU: {branch_taken, result}; undefined op codes give 0 / not taken.
  function automatic logic [32:0] alu_fn(input logic [1:0] sel, input logic [2:0] op,
                                         input logic [31:0] a, input logic [31:0] b);
    if (sel == 2'b00) begin
      case (op)
        3'd0: return {1'b0, a + b};
        3'd1: return {1'b0, a - b};
        3'd2: return {1'b0, a & b};
        3'd3: return {1'b0, a | b};
        3'd4: return {1'b0, a ^ b};
        default: return 33'd0;
      endcase
    end else if (sel == 2'b01) begin
      case (op)
        3'd0: return {1'b0, a + 32'd1};
        3'd1: return {1'b0, a - 32'd1};
        default: return 33'd0;
      endcase
    end else if (sel == 2'b10) begin
      case (op)
        3'd0: return {a == b, 32'd0};
        3'd1: return {a != b, 32'd0};
        3'd2: return {$signed(a) < $signed(b), 32'd0};
        3'd3: return {$signed(a) >= $signed(b), 32'd0};
        default: return 33'd0;
      endcase
    end
    return 33'd0;
  endfunction

  always @(posedge clk)
    {bus.alu_bt, bus.alu_result} <= alu_fn(bus.alu_sel, bus.alu_control,
                                           bus.alu_read_data1, bus.alu_read_data2);

  // Architectural reference state.
  logic [31:0]      m_regs [8];
  logic [PC_W-1:0]  m_pc;
  logic [CNT_W-1:0] m_cnt;
  logic             m_ill;

  typedef struct packed {
    logic [1:0]       sel;
    logic [2:0]       ctrl;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [PC_W-1:0]  pc;
    logic [CNT_W-1:0] cnt;
    logic             ill;
    logic [7:0][31:0] regs;
    logic             k_en;
    logic [2:0]       k_addr;
    logic [31:0]      k_val;
    logic             kp_en;
    logic [PC_W-1:0]  kp_val;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 32'd0;
    m_pc  = '0;
    m_cnt = '0;
    m_ill = 1'b0;
  endtask

  function automatic logic [31:0] mk(input logic [1:0] s, input logic [2:0] c,
                                     input logic [2:0] rd, input logic [2:0] rs1,
                                     input logic [2:0] rs2, input logic [7:0] off);
    return {s, c, rd, rs1, rs2, off, 10'h000};
  endfunction

  // Called and returns on a falling edge; leaves junk on instr with valid high
  // through DECODE..WB, which the DUT must ignore.
  task automatic issue(input logic [31:0] w, input int stall,
                       input bit k_en = 1'b0, input logic [2:0] k_addr = 3'd0,
                       input logic [31:0] k_val = 32'd0,
                       input bit kp_en = 1'b0, input logic [PC_W-1:0] kp_val = '0);
    int t = 0;
    exp_t e;
    logic [32:0] r;
    logic [1:0] s;
    while (bus.fetch_req !== 1'b1 && t < 64) begin
      @(negedge clk);
      t++;
    end
    if (t >= 64) begin
      check("fetch_req timeout", 32'd0, 32'd1);
      return;
    end
    check("fetch_addr at fetch", 32'(bus.fetch_addr), 32'(m_pc));
    for (int i = 0; i < stall; i++) begin
      bus.instr_valid = 1'b0;
      bus.instr       = $urandom;
      @(negedge clk);
      check("stall fetch_req", 32'(bus.fetch_req), 32'd1);
      check("stall fetch_addr", 32'(bus.fetch_addr), 32'(m_pc));
    end
    bus.instr       = w;
    bus.instr_valid = 1'b1;
    @(posedge clk);
    s      = w[31:30];
    e.sel  = (s == 2'b11) ? 2'b00 : s;
    e.ctrl = w[29:27];
    e.a    = m_regs[w[23:21]];
    e.b    = m_regs[w[20:18]];
    r      = alu_fn(e.sel, e.ctrl, e.a, e.b);
    if (s == 2'b11) begin
      m_ill = 1'b1;
      m_pc  = m_pc + 8'd1;
    end else if (s == 2'b10) begin
      m_pc = r[32] ? m_pc + w[17:10] : m_pc + 8'd1;
    end else begin
      if (w[26:24] != 3'd0) m_regs[w[26:24]] = r[31:0];
      m_pc = m_pc + 8'd1;
    end
    m_cnt = m_cnt + 16'd1;
    e.pc  = m_pc;
    e.cnt = m_cnt;
    e.ill = m_ill;
    for (int i = 0; i < 8; i++) e.regs[i] = m_regs[i];
    e.k_en   = k_en;
    e.k_addr = k_addr;
    e.k_val  = k_val;
    e.kp_en  = kp_en;
    e.kp_val = kp_val;
    sb.push_back(e);
    @(negedge clk);
    bus.instr = $urandom;
  endtask

  task automatic drain();
    int t = 0;
    bus.instr_valid = 1'b0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("drain queue empty", 32'(sb.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // Monitor: on each retire pulse, pop the prediction and compare.
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && retire === 1'b1) begin
        prev_ret = last_ret;
        last_ret = cyc;
        if (sb.size() == 0) begin
          check("unexpected retire", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("alu_sel", 32'(bus.alu_sel), 32'(mon_e.sel));
          check("alu_control", 32'(bus.alu_control), 32'(mon_e.ctrl));
          check("alu_read_data1", bus.alu_read_data1, mon_e.a);
          check("alu_read_data2", bus.alu_read_data2, mon_e.b);
          @(negedge clk);
          check("retire pulse width", 32'(retire), 32'd0);
          check("pc after retire", 32'(bus.fetch_addr), 32'(mon_e.pc));
          check("retired_cnt", 32'(retired_cnt), 32'(mon_e.cnt));
          check("illegal", 32'(illegal), 32'(mon_e.ill));
          for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #0.4;
            check($sformatf("reg%0d", i), dbg_data, mon_e.regs[i]);
          end
          if (mon_e.k_en) begin
            dbg_addr = mon_e.k_addr;
            #0.4;
            check($sformatf("directed reg%0d", mon_e.k_addr), dbg_data, mon_e.k_val);
          end
          if (mon_e.kp_en)
            check("directed branch target", 32'(bus.fetch_addr), 32'(mon_e.kp_val));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] s;
    int         pick;
    model_reset();
    bus.instr_valid = 1'b0;
    bus.instr       = 32'd0;
    repeat (2) @(negedge clk);
    check("reset fetch_req", 32'(bus.fetch_req), 32'd0);
    check("reset fetch_addr", 32'(bus.fetch_addr), 32'd0);
    check("reset alu_sel", 32'(bus.alu_sel), 32'd0);
    check("reset alu_control", 32'(bus.alu_control), 32'd0);
    check("reset operand A", bus.alu_read_data1, 32'd0);
    check("reset operand B", bus.alu_read_data2, 32'd0);
    check("reset retire", 32'(retire), 32'd0);
    check("reset illegal", 32'(illegal), 32'd0);
    check("reset retired_cnt", 32'(retired_cnt), 32'd0);

    reset = 1'b1;
    run   = 1'b1;
    @(negedge clk);

    // r1 = 0, then three increments with instr_valid held high.
    issue(mk(RR, ADD, 3'd1, 3'd0, 3'd0, 8'h00), 0);
    issue(mk(ID, INC, 3'd1, 3'd1, 3'd0, 8'h00), 0);
    issue(mk(ID, INC, 3'd1, 3'd1, 3'd0, 8'h00), 0);
    issue(mk(ID, INC, 3'd1, 3'd1, 3'd0, 8'h00), 0, 1'b1, 3'd1, 32'd3);
    drain();
    check("retired_cnt after 4", 32'(retired_cnt), 32'd4);
    check("fetch_addr after 4", 32'(bus.fetch_addr), 32'd4);
    check("retire spacing", 32'(last_ret - prev_ret), 32'd4);

    // r2 = 5, then reg-reg ops, rd=0 discard and branches incl. PC wrap.
    for (int i = 0; i < 5; i++)
      issue(mk(ID, INC, 3'd2, 3'd2, 3'd0, 8'h00), 0, i == 4, 3'd2, 32'd5);
    issue(mk(RR, SUB,  3'd3, 3'd2, 3'd1, 8'h00), 0, 1'b1, 3'd3, 32'd2);
    issue(mk(BR, BEQ,  3'd0, 3'd1, 3'd1, 8'hFC), 0, 1'b0, 3'd0, 32'd0, 1'b1, 8'd6);
    issue(mk(RR, XOR_, 3'd4, 3'd1, 3'd2, 8'h00), 0, 1'b1, 3'd4, 32'd6);
    issue(mk(RR, AND_, 3'd5, 3'd1, 3'd2, 8'h00), 0, 1'b1, 3'd5, 32'd1);
    issue(mk(RR, OR_,  3'd6, 3'd1, 3'd2, 8'h00), 0, 1'b1, 3'd6, 32'd7);
    issue(mk(RR, ADD,  3'd0, 3'd1, 3'd2, 8'h00), 0, 1'b1, 3'd0, 32'd0);
    issue(mk(BR, BNE,  3'd0, 3'd1, 3'd1, 8'hFC), 0, 1'b0, 3'd0, 32'd0, 1'b1, 8'd11);
    issue(mk(BR, BLT,  3'd0, 3'd1, 3'd2, 8'h02), 0, 1'b0, 3'd0, 32'd0, 1'b1, 8'd13);
    issue(mk(BR, BEQ,  3'd0, 3'd0, 3'd0, 8'd127), 0, 1'b0, 3'd0, 32'd0, 1'b1, 8'd140);
    issue(mk(BR, BEQ,  3'd0, 3'd0, 3'd0, 8'd114), 0, 1'b0, 3'd0, 32'd0, 1'b1, 8'd254);
    issue(mk(BR, BEQ,  3'd0, 3'd0, 3'd0, 8'd5),   0, 1'b0, 3'd0, 32'd0, 1'b1, 8'd3);

    // Five-cycle fetch stall, then an illegal-class instruction that must not write r1.
    issue(mk(RR, ADD, 3'd7, 3'd1, 3'd2, 8'h00), 5, 1'b1, 3'd7, 32'd8);
    issue(mk(BAD, ADD, 3'd1, 3'd2, 3'd2, 8'h00), 0, 1'b1, 3'd1, 32'd3);
    issue(mk(RR, ADD, 3'd6, 3'd1, 3'd1, 8'h00), 0);
    drain();
    check("illegal sticky", 32'(illegal), 32'd1);

    // run dropped in DECODE: instruction completes, then park in IDLE.
    issue(mk(ID, INC, 3'd5, 3'd5, 3'd0, 8'h00), 0);
    run = 1'b0;
    drain();
    repeat (3) begin
      @(negedge clk);
      check("parked fetch_req", 32'(bus.fetch_req), 32'd0);
    end
    run = 1'b1;
    @(negedge clk);

    // Reset while the instruction sits in EXEC.
    issue(mk(ID, INC, 3'd3, 3'd3, 3'd0, 8'h00), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid reset fetch_req", 32'(bus.fetch_req), 32'd0);
    check("mid reset fetch_addr", 32'(bus.fetch_addr), 32'd0);
    check("mid reset alu_sel", 32'(bus.alu_sel), 32'd0);
    check("mid reset alu_control", 32'(bus.alu_control), 32'd0);
    check("mid reset operand A", bus.alu_read_data1, 32'd0);
    check("mid reset operand B", bus.alu_read_data2, 32'd0);
    check("mid reset retire", 32'(retire), 32'd0);
    check("mid reset illegal", 32'(illegal), 32'd0);
    check("mid reset retired_cnt", 32'(retired_cnt), 32'd0);
    sb.delete();
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Randomised instruction stream with random fetch stalls.
    for (int n = 0; n < 150; n++) begin
      pick = $urandom_range(0, 15);
      s = (pick < 6) ? RR : (pick < 11) ? ID : (pick < 15) ? BR : BAD;
      issue(mk(s, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
               3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
               8'($urandom_range(0, 255))) | 32'($urandom_range(0, 1023)),
            $urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
